// File: rtl/row_min_ctrl_if.sv
// SRAM read port and FindMin handshake bundle for row_min_ctrl.
// master = row_min_ctrl side, slave = SRAM/FindMin side.
interface row_min_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 8
);
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [15:0]           mem_rd_data;
  logic [LANES*16-1:0]   fm_numbers;
  logic                  fm_start;
  logic                  fm_done;
  logic [15:0]           fm_result;

  modport master (
    output mem_rd_en, mem_addr, fm_numbers, fm_start,
    input  mem_rd_data, fm_done, fm_result
  );

  modport slave (
    input  mem_rd_en, mem_addr, fm_numbers, fm_start,
    output mem_rd_data, fm_done, fm_result
  );
endinterface

// File: rtl/row_min_ctrl.sv
// Row-minimum sequencer: streams an SRAM row through a shared 8-lane FindMin unit
// chunk by chunk. Optional macro ROW_MIN_CHUNK_IDX_EN adds the min_chunk index output.
module row_min_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       row_min,
  row_min_ctrl_if.master    bus
`ifdef ROW_MIN_CHUNK_IDX_EN
  ,
  output logic [ADDR_W-3:0] min_chunk
`endif
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_W  = LANES * DATA_W;
  localparam int unsigned SEL_W  = $clog2(LANES);
  localparam int unsigned CNT_W  = SEL_W + 1;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam logic [DATA_W-1:0] MAX_POS = 16'h7FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_GAP,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nwords_q, nwords_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_W-1:0]  lanes_q, lanes_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              empty_q, empty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] row_min_q, row_min_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fm_start_q, fm_start_d;

  logic              load;
  logic [LEN_W-1:0]  load_rem;
  logic [ADDR_W-1:0] load_ptr;
  logic [SEL_W-1:0]  lane_sel;

`ifdef ROW_MIN_CHUNK_IDX_EN
  logic [ADDR_W-3:0] chunk_idx_q, chunk_idx_d;
  logic [ADDR_W-3:0] min_chunk_q, min_chunk_d;
`endif

  // Words in the next chunk: a full set of lanes, or whatever is left of the row.
  function automatic logic [CNT_W-1:0] chunk_words(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(LANES)) begin
      chunk_words = CNT_W'(LANES);
    end else begin
      chunk_words = rem[CNT_W-1:0];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    nwords_d    = nwords_q;
    remaining_d = remaining_q;
    rd_ptr_d    = rd_ptr_q;
    lanes_d     = lanes_q;
    run_min_d   = run_min_q;
    res_d       = res_q;
    empty_d     = empty_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    row_min_d   = row_min_q;
    rd_en_d     = 1'b0;
    addr_d      = '0;
    fm_start_d  = 1'b0;
    load        = 1'b0;
    load_rem    = remaining_q;
    load_ptr    = rd_ptr_q;
    lane_sel    = SEL_W'(cnt_q - CNT_W'(1));
`ifdef ROW_MIN_CHUNK_IDX_EN
    chunk_idx_d = chunk_idx_q;
    min_chunk_d = min_chunk_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          err_d     = 1'b0;
          run_min_d = MAX_POS;
`ifdef ROW_MIN_CHUNK_IDX_EN
          chunk_idx_d = '0;
          min_chunk_d = '0;
`endif
          if (len == '0) begin
            empty_d = 1'b1;
            state_d = S_FIN;
          end else begin
            empty_d  = 1'b0;
            load     = 1'b1;
            load_rem = len;
            load_ptr = base_addr;
          end
        end
      end

      // Read in cycles 0..nwords-1, capture one cycle behind into lane cnt-1.
      S_FETCH: begin
        if (cnt_q != '0) begin
          lanes_d[{lane_sel, 4'b0000} +: DATA_W] = bus.mem_rd_data;
        end
        if (cnt_q == nwords_q) begin
          state_d    = S_CALC;
          fm_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) < nwords_q) begin
            rd_en_d  = 1'b1;
            addr_d   = rd_ptr_q;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          end
        end
      end

      S_CALC: begin
        fm_start_d = 1'b1;
        if (bus.fm_done) begin
          res_d      = bus.fm_result;
          fm_start_d = 1'b0;
          state_d    = S_GAP;
        end
      end

      S_GAP: begin
        if ($signed(res_q) < $signed(run_min_q)) begin
          run_min_d = res_q;
`ifdef ROW_MIN_CHUNK_IDX_EN
          min_chunk_d = chunk_idx_q;
`endif
        end
`ifdef ROW_MIN_CHUNK_IDX_EN
        chunk_idx_d = chunk_idx_q + (ADDR_W-2)'(1);
`endif
        if (remaining_q != '0) begin
          load = 1'b1;
        end else begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        err_d     = empty_q;
        row_min_d = run_min_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Chunk setup shared by the IDLE and GAP entries into FETCH.
    if (load) begin
      nwords_d    = chunk_words(load_rem);
      remaining_d = load_rem - LEN_W'(nwords_d);
      cnt_d       = '0;
      lanes_d     = {LANES{MAX_POS}};
      rd_en_d     = 1'b1;
      addr_d      = load_ptr;
      rd_ptr_d    = load_ptr + ADDR_W'(1);
      state_d     = S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : data_regs
    if (!rst_n) begin
      cnt_q       <= '0;
      nwords_q    <= '0;
      remaining_q <= '0;
      rd_ptr_q    <= '0;
      lanes_q     <= '0;
      run_min_q   <= '0;
      res_q       <= '0;
      empty_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      row_min_q   <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      fm_start_q  <= 1'b0;
`ifdef ROW_MIN_CHUNK_IDX_EN
      chunk_idx_q <= '0;
      min_chunk_q <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      nwords_q    <= nwords_d;
      remaining_q <= remaining_d;
      rd_ptr_q    <= rd_ptr_d;
      lanes_q     <= lanes_d;
      run_min_q   <= run_min_d;
      res_q       <= res_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      row_min_q   <= row_min_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      fm_start_q  <= fm_start_d;
`ifdef ROW_MIN_CHUNK_IDX_EN
      chunk_idx_q <= chunk_idx_d;
      min_chunk_q <= min_chunk_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign row_min        = row_min_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.fm_numbers = lanes_q;
  assign bus.fm_start   = fm_start_q;
`ifdef ROW_MIN_CHUNK_IDX_EN
  assign min_chunk      = min_chunk_q;
`endif

endmodule

// File: tb/tb_row_min_ctrl.sv
// Scoreboard bench for row_min_ctrl with SRAM and FindMin behavioural models.
// Honours ROW_MIN_CHUNK_IDX_EN when the design is built with it.
module tb_row_min_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LANES  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       row_min;
`ifdef ROW_MIN_CHUNK_IDX_EN
  logic [ADDR_W-3:0] min_chunk;
`endif

  row_min_ctrl_if #(.ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  row_min_ctrl #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .row_min   (row_min),
    .bus       (bus)
`ifdef ROW_MIN_CHUNK_IDX_EN
    ,
    .min_chunk (min_chunk)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: one-cycle read latency
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  function automatic logic [15:0] lane_min(input logic [127:0] v);
    logic signed [15:0] m;
    m = 16'sh7FFF;
    for (int i = 0; i < 8; i++) begin
      if ($signed(v[16*i +: 16]) < m) m = v[16*i +: 16];
    end
    return m;
  endfunction

  // FindMin model with programmable done latency
  int fm_lat = 1;
  int fm_cnt = 0;
  always @(posedge clk) begin
    if (bus.fm_start !== 1'b1) begin
      fm_cnt      <= 0;
      bus.fm_done <= 1'b0;
    end else if (bus.fm_done) begin
      bus.fm_done <= 1'b0;
    end else if (fm_cnt >= fm_lat - 1) begin
      bus.fm_done   <= 1'b1;
      bus.fm_result <= lane_min(bus.fm_numbers);
    end else begin
      fm_cnt <= fm_cnt + 1;
    end
  end

  typedef struct packed {
    logic [15:0] rmin;
    logic        err;
    logic [5:0]  idx;
  } res_t;

  logic [7:0]   exp_addr_q [$];
  logic [127:0] exp_chunk_q [$];
  res_t         exp_res_q [$];

  logic         prev_fm_start = 1'b0;
  logic         prev_fm_done = 1'b0;
  logic [127:0] calc_numbers = '0;

  always @(negedge clk) begin : monitor
    res_t r;
    if (!rst_n) begin
      prev_fm_start = 1'b0;
      prev_fm_done  = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        if (exp_addr_q.size() == 0) check("rd_unexpected", 128'(1), 128'(0));
        else check("rd_addr", 128'(bus.mem_addr), 128'(exp_addr_q.pop_front()));
      end
      if (prev_fm_done) check("fm_gap", 128'(bus.fm_start), 128'(0));
      if (bus.fm_start && !prev_fm_start) begin
        calc_numbers = bus.fm_numbers;
        if (exp_chunk_q.size() == 0) check("calc_unexpected", 128'(1), 128'(0));
        else check("fm_numbers", bus.fm_numbers, exp_chunk_q.pop_front());
      end
      if (bus.fm_start && prev_fm_start) check("fm_stable", bus.fm_numbers, calc_numbers);
      prev_fm_done  = bus.fm_start && bus.fm_done;
      prev_fm_start = bus.fm_start;
      if (done) begin
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", 128'(1), 128'(0));
        end else begin
          r = exp_res_q.pop_front();
          check("row_min", 128'(row_min), 128'(r.rmin));
          check("err", 128'(err), 128'(r.err));
`ifdef ROW_MIN_CHUNK_IDX_EN
          check("min_chunk", 128'(min_chunk), 128'(r.idx));
`endif
          check("busy_at_done", 128'(busy), 128'(0));
        end
      end
    end
  end

  // Reference: chunk the row, fill empty lanes, fold chunk minima with strict less-than.
  task automatic expect_row(input logic [7:0] b, input logic [8:0] l, output logic [15:0] rmin);
    logic signed [15:0] run;
    logic signed [15:0] cmin;
    logic [127:0]       chunk;
    logic [7:0]         a;
    logic [5:0]         idx;
    int                 nchunks;
    int                 w;
    res_t               r;
    run = 16'sh7FFF;
    idx = '0;
    nchunks = (int'(l) + 7) / 8;
    for (int c = 0; c < nchunks; c++) begin
      chunk = {8{16'h7FFF}};
      cmin  = 16'sh7FFF;
      for (int k = 0; k < 8; k++) begin
        w = c * 8 + k;
        if (w < int'(l)) begin
          a = 8'(int'(b) + w);
          exp_addr_q.push_back(a);
          chunk[16*k +: 16] = mem[a];
          if ($signed(mem[a]) < cmin) cmin = mem[a];
        end
      end
      exp_chunk_q.push_back(chunk);
      if (cmin < run) begin
        run = cmin;
        idx = 6'(c);
      end
    end
    r.rmin = run;
    r.err  = (l == '0);
    r.idx  = idx;
    exp_res_q.push_back(r);
    rmin = run;
  endtask

  task automatic run_row(input logic [7:0] b, input logic [8:0] l,
                         input int repulse_at, input int exp_lat);
    int          n;
    logic [15:0] rmin;
    expect_row(b, l, rmin);
    base_addr = b;
    len = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'(1));
    n = 1;
    while (!done && n < 2000) begin
      if (n == repulse_at) begin
        start = 1'b1;
        base_addr = 8'h80;
        len = 9'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 128'(0), 128'(1));
    else if (exp_lat > 0) check("done_latency", 128'(n), 128'(exp_lat));
    @(posedge clk); #1;
    check("done_pulse", 128'(done), 128'(0));
    check("row_min_hold", 128'(row_min), 128'(rmin));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_err"}, 128'(err), 128'(0));
    check({tag, "_row_min"}, 128'(row_min), 128'(0));
    check({tag, "_rd_en"}, 128'(bus.mem_rd_en), 128'(0));
    check({tag, "_addr"}, 128'(bus.mem_addr), 128'(0));
    check({tag, "_fm_start"}, 128'(bus.fm_start), 128'(0));
    check({tag, "_fm_numbers"}, bus.fm_numbers, 128'(0));
`ifdef ROW_MIN_CHUNK_IDX_EN
    check({tag, "_min_chunk"}, 128'(min_chunk), 128'(0));
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] t1 [8];
    int          n;
    t1 = '{16'd5, 16'd3, 16'd9, 16'hFFFE, 16'd7, 16'd1, 16'd0, 16'd4};
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(100, 30000));

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single full chunk with a negative minimum
    for (int i = 0; i < 8; i++) mem[i] = t1[i];
    run_row(8'h00, 9'd8, -1, -1);
    check("t1_row_min", 128'(row_min), 128'(16'hFFFE));
    check("t1_err", 128'(err), 128'(0));

    // Three chunks, the last one partial
    mem[8'h20 + 17] = 16'hFF9C;
    run_row(8'h20, 9'd20, -1, -1);
    check("t2_row_min", 128'(row_min), 128'(16'hFF9C));
`ifdef ROW_MIN_CHUNK_IDX_EN
    check("t2_min_chunk", 128'(min_chunk), 128'(2));
`endif

    // Empty row
    run_row(8'h40, 9'd0, -1, 2);
    check("t3_err", 128'(err), 128'(1));
    check("t3_row_min", 128'(row_min), 128'(16'h7FFF));

    // Address wrap past the top of the SRAM
    mem[8'h01] = 16'hFFF9;
    run_row(8'hFC, 9'd8, -1, -1);
    check("t4_row_min", 128'(row_min), 128'(16'hFFF9));
    check("t4_err_cleared", 128'(err), 128'(0));

    // Single word at the top address, and a tie across chunks
    run_row(8'hFF, 9'd1, -1, -1);
    mem[8'h51] = 16'hFFFB;
    mem[8'h60] = 16'hFFFB;
    run_row(8'h50, 9'd17, -1, -1);
`ifdef ROW_MIN_CHUNK_IDX_EN
    check("tie_min_chunk", 128'(min_chunk), 128'(0));
`endif

    // Slow FindMin must give identical results
    fm_lat = 6;
    run_row(8'h20, 9'd20, -1, -1);
    check("t6_row_min", 128'(row_min), 128'(16'hFF9C));
    run_row(8'hFC, 9'd8, -1, -1);
    check("t6_wrap_row_min", 128'(row_min), 128'(16'hFFF9));
    fm_lat = 1;

    // Full-size row with the most negative value
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h37 + 8'd200] = 16'h8000;
    run_row(8'h37, 9'd256, -1, -1);
    check("full_row_min", 128'(row_min), 128'(16'h8000));

    // start re-pulsed while busy is ignored
    run_row(8'h20, 9'd20, 5, -1);

    // Reset while FindMin is running aborts without a done pulse
    begin
      logic [15:0] dummy;
      expect_row(8'h00, 9'd20, dummy);
    end
    base_addr = 8'h00;
    len = 9'd20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!bus.fm_start && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_calc", 128'(bus.fm_start), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    exp_addr_q.delete();
    exp_chunk_q.delete();
    exp_res_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) mem[i] = t1[i];
    run_row(8'h00, 9'd8, -1, -1);
    check("post_reset_row_min", 128'(row_min), 128'(16'hFFFE));

    repeat (5) @(posedge clk);
    #1;
    check("sb_addr_drain", 128'(exp_addr_q.size()), 128'(0));
    check("sb_chunk_drain", 128'(exp_chunk_q.size()), 128'(0));
    check("sb_res_drain", 128'(exp_res_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
